// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - CORE/DMA arbiter for memory data port 2 with starvation and burst limits
module dmem_port_arbiter #(
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [3:0]  core_wmask,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [3:0]  dma_wmask,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {ST_OPEN = 1'b0, ST_BURST = 1'b1} state_t;

  localparam logic [7:0] L_MAX_WAIT  = 8'(MAX_WAIT);
  localparam logic [7:0] L_MAX_BURST = 8'(MAX_BURST);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_nxt;
  logic [7:0]  r_burst_cnt;
  logic [7:0]  w_burst_cnt_nxt;
  logic        w_core_gnt;
  logic        w_dma_gnt;
  logic        w_force_dma;
  logic        w_open_arb;
  logic        w_rd_grant;
  logic        r_core_rvalid;
  logic        r_dma_rvalid;
  logic [31:0] r_rdata;

  // DMA has waited long enough that it wins over CORE in the open state
  assign w_force_dma = (r_wait_cnt == L_MAX_WAIT);

  // Grant decision and next state; leaving BURST falls through to open arbitration in the same cycle
  always_comb begin
    w_state_nxt     = r_state;
    w_burst_cnt_nxt = r_burst_cnt;
    w_core_gnt      = 1'b0;
    w_dma_gnt       = 1'b0;
    w_open_arb      = 1'b0;

    if (r_state == ST_BURST) begin
      if (dma_req && dma_lock) begin
        if (r_burst_cnt < L_MAX_BURST) begin
          w_dma_gnt       = 1'b1;
          w_burst_cnt_nxt = r_burst_cnt + 8'd1;
        end else if (core_req) begin
          // one CORE slot after a full burst, then DMA resumes
          w_core_gnt      = 1'b1;
          w_burst_cnt_nxt = 8'd0;
        end else begin
          w_dma_gnt       = 1'b1;
          w_burst_cnt_nxt = 8'd1;
        end
      end else begin
        w_state_nxt     = ST_OPEN;
        w_burst_cnt_nxt = 8'd0;
        w_open_arb      = 1'b1;
      end
    end else begin
      w_open_arb = 1'b1;
    end

    if (w_open_arb) begin
      if (dma_req && (w_force_dma || !core_req)) begin
        w_dma_gnt = 1'b1;
        if (dma_lock) begin
          w_state_nxt     = ST_BURST;
          w_burst_cnt_nxt = 8'd1;
        end
      end else if (core_req) begin
        w_core_gnt = 1'b1;
      end
    end
  end

  // Starvation counter: counts cycles DMA is left pending, saturates at the force threshold
  always_comb begin
    w_wait_cnt_nxt = 8'd0;
    if (dma_req && !w_dma_gnt) begin
      if (r_wait_cnt == L_MAX_WAIT) begin
        w_wait_cnt_nxt = r_wait_cnt;
      end else begin
        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
      end
    end
  end

  // Steer the granted requester onto the memory pins; idle pins are held at zero
  always_comb begin
    mem_we    = 1'b0;
    mem_wmask = 4'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (w_core_gnt) begin
      mem_we    = core_we;
      mem_wmask = core_we ? core_wmask : 4'h0;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (w_dma_gnt) begin
      mem_we    = dma_we;
      mem_wmask = dma_we ? dma_wmask : 4'h0;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign w_rd_grant = (w_core_gnt && !core_we) || (w_dma_gnt && !dma_we);

  // Arbitration state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_OPEN;
      r_wait_cnt  <= 8'd0;
      r_burst_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // Capture read data at the end of a read grant and flag its owner for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata       <= 32'h0;
      r_core_rvalid <= 1'b0;
      r_dma_rvalid  <= 1'b0;
    end else begin
      r_core_rvalid <= w_core_gnt && !core_we;
      r_dma_rvalid  <= w_dma_gnt && !dma_we;
      if (w_rd_grant) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  assign core_gnt    = w_core_gnt;
  assign dma_gnt     = w_dma_gnt;
  assign core_rvalid = r_core_rvalid;
  assign dma_rvalid  = r_dma_rvalid;
  assign rdata       = r_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int MAX_BURST = 16;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_we, core_gnt, core_rvalid;
  logic [3:0]  core_wmask;
  logic [31:0] core_addr, core_wdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [3:0]  dma_wmask;
  logic [31:0] dma_addr, dma_wdata;
  logic [31:0] rdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // memory model and preload path
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pre_vals [256];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  // reference arbiter state, owned by the monitor
  bit          m_burst;
  int          m_wc, m_bc;
  logic [31:0] m_rdata;
  logic [32:0] sb [$];
  logic        ec, ed;
  logic [68:0] eb;
  logic [1:0]  erv;
  logic [32:0] hd;

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_wmask(core_wmask),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_wmask(dma_wmask),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_lock(dma_lock),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_wmask);
  end

  // reference arbiter + read scoreboard, evaluated mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      m_burst = 0; m_wc = 0; m_bc = 0; m_rdata = 32'h0;
      sb.delete();
      if (pre_we) ref_mem[pre_idx] = pre_data;
      checks++;
      if (core_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_rvalid got core=%b dma=%b need 0/0", core_rvalid, dma_rvalid);
      end
    end else begin
      erv = 2'b00;
      if (sb.size() > 0) begin
        hd = sb.pop_front();
        erv = {~hd[32], hd[32]};
        m_rdata = hd[31:0];
      end
      checks++;
      if ({core_rvalid, dma_rvalid} !== erv || rdata !== m_rdata) begin
        errors++;
        $display("FAIL rvalid_rdata got rv=%b rdata=%h need rv=%b rdata=%h",
                 {core_rvalid, dma_rvalid}, rdata, erv, m_rdata);
      end

      ec = 0; ed = 0;
      if (m_burst && !(dma_req && dma_lock)) begin
        m_burst = 0; m_bc = 0;
      end
      if (m_burst) begin
        if (m_bc < MAX_BURST) begin ed = 1; m_bc = m_bc + 1; end
        else if (core_req) begin ec = 1; m_bc = 0; end
        else begin ed = 1; m_bc = 1; end
      end else begin
        if (dma_req && (m_wc == MAX_WAIT || !core_req)) begin
          ed = 1;
          if (dma_lock) begin m_burst = 1; m_bc = 1; end
        end else if (core_req) begin
          ec = 1;
        end
      end
      if (dma_req && !ed) m_wc = (m_wc == MAX_WAIT) ? m_wc : m_wc + 1;
      else m_wc = 0;

      checks++;
      if ({core_gnt, dma_gnt} !== {ec, ed}) begin
        errors++;
        $display("FAIL grant got core=%b dma=%b need core=%b dma=%b", core_gnt, dma_gnt, ec, ed);
      end

      if (ec) eb = {core_we, core_we ? core_wmask : 4'h0, core_addr, core_wdata};
      else if (ed) eb = {dma_we, dma_we ? dma_wmask : 4'h0, dma_addr, dma_wdata};
      else eb = '0;
      checks++;
      if ({mem_we, mem_wmask, mem_addr, mem_wdata} !== eb) begin
        errors++;
        $display("FAIL mem_bus got %h need %h", {mem_we, mem_wmask, mem_addr, mem_wdata}, eb);
      end

      if (ec && !core_we) sb.push_back({1'b0, ref_mem[core_addr[9:2]]});
      if (ed && !dma_we)  sb.push_back({1'b1, ref_mem[dma_addr[9:2]]});
      if (ec && core_we)
        ref_mem[core_addr[9:2]] = merge(ref_mem[core_addr[9:2]], core_wdata, core_wmask);
      if (ed && dma_we)
        ref_mem[dma_addr[9:2]] = merge(ref_mem[dma_addr[9:2]], dma_wdata, dma_wmask);
    end
  end

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_wmask = 4'h0; core_addr = 32'h0; core_wdata = 32'h0;
    dma_req = 0; dma_we = 0; dma_wmask = 4'h0; dma_addr = 32'h0; dma_wdata = 32'h0;
    dma_lock = 0;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      pre_vals[i] = (i == 'h40) ? 32'hDEADBEEF : $urandom;
      pre_we = 1; pre_idx = 8'(i); pre_data = pre_vals[i];
      @(posedge clk); #1;
    end
    pre_we = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_we, mem_wmask, mem_addr, mem_wdata, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_in_reset got gnt=%b%b rv=%b%b rdata=%h need all 0",
               core_gnt, dma_gnt, core_rvalid, dma_rvalid, rdata);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_we, mem_wmask, mem_addr, mem_wdata, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_idle got gnt=%b%b mem_addr=%h rdata=%h need all 0",
               core_gnt, dma_gnt, mem_addr, rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_core_read();
    core_req = 1; core_we = 0; core_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({core_gnt, dma_gnt} !== 2'b10) begin
      errors++; $display("FAIL core_read_gnt got %b%b need 10", core_gnt, dma_gnt);
    end
    @(posedge clk); #1;
    core_req = 0;
    @(negedge clk);
    checks++;
    if (core_rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL core_read_data got rv=%b rdata=%h need 1 deadbeef", core_rvalid, rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_priority_wait();
    logic [1:0] exp;
    core_req = 1; core_we = 0; core_addr = 32'h0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h4; dma_lock = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      exp = (i == 8 || i == 17) ? 2'b01 : 2'b10;
      checks++;
      if ({core_gnt, dma_gnt} !== exp) begin
        errors++; $display("FAIL wait_force cycle %0d got %b%b need %b", i, core_gnt, dma_gnt, exp);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_dma_burst();
    int nd;
    logic dg;
    logic [1:0] exp;
    nd = 0;
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_wmask = 4'hF;
    dma_addr = 32'h300; dma_wdata = 32'hA5000000;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      exp = (i == 16) ? 2'b10 : 2'b01;
      checks++;
      if ({core_gnt, dma_gnt} !== exp) begin
        errors++; $display("FAIL burst_limit cycle %0d got %b%b need %b", i, core_gnt, dma_gnt, exp);
      end
      dg = dma_gnt;
      @(posedge clk); #1;
      core_req = 1; core_we = 0; core_addr = 32'h40;
      if (dg) begin
        nd++;
        dma_addr = dma_addr + 32'd4;
        dma_wdata = dma_wdata + 32'd1;
        if (nd == 20) begin dma_req = 0; dma_lock = 0; end
      end
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write_raw();
    logic [31:0] exp;
    exp = (pre_vals['h80] & 32'hFFFF00FF) | 32'h0000AB00;
    core_req = 1; core_we = 1; core_wmask = 4'b0010; core_wdata = 32'h0000AB00; core_addr = 32'h200;
    @(negedge clk);
    checks++;
    if (core_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wmask !== 4'b0010) begin
      errors++; $display("FAIL byte_write got gnt=%b we=%b mask=%b need 1 1 0010", core_gnt, mem_we, mem_wmask);
    end
    @(posedge clk); #1;
    idle_inputs();
    dma_req = 1; dma_we = 0; dma_wmask = 4'hF; dma_addr = 32'h200;
    @(negedge clk);
    checks++;
    if (dma_gnt !== 1'b1 || mem_we !== 1'b0 || mem_wmask !== 4'h0) begin
      errors++; $display("FAIL dma_read_bus got gnt=%b we=%b mask=%b need 1 0 0000", dma_gnt, mem_we, mem_wmask);
    end
    @(posedge clk); #1;
    dma_req = 0;
    @(negedge clk);
    checks++;
    if (dma_rvalid !== 1'b1 || core_rvalid !== 1'b0 || rdata !== exp) begin
      errors++; $display("FAIL raw_data got rv=%b%b rdata=%h need 01 %h", core_rvalid, dma_rvalid, rdata, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dma_gnt !== 1'b1) begin
        errors++; $display("FAIL burst_read cycle %0d got dma_gnt=%b need 1", i, dma_gnt);
      end
      if (i < 2) begin
        @(posedge clk); #1;
        dma_addr = dma_addr + 32'd4;
      end
    end
    #2;
    rst_n = 0;
    idle_inputs();
    #1;
    checks++;
    if (core_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
      errors++; $display("FAIL async_reset_rvalid got %b%b need 00", core_rvalid, dma_rvalid);
    end
    @(posedge clk); #1;
    checks++;
    if (dma_rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_pending_read got rv=%b rdata=%h need 0 0", dma_rvalid, rdata);
    end
    @(posedge clk); #1;
    rst_n = 1;
    core_req = 1; core_we = 0; core_addr = 32'h8;
    dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 32'hC;
    @(negedge clk);
    checks++;
    if ({core_gnt, dma_gnt} !== 2'b10) begin
      errors++; $display("FAIL reset_open_state got %b%b need 10", core_gnt, dma_gnt);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic cg, dg;
    cg = 0; dg = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(core_req && !cg)) begin
        core_req = ($urandom_range(0, 9) < 7);
        core_we = 1'($urandom_range(0, 1));
        core_wmask = 4'($urandom);
        core_addr = {22'd0, 8'($urandom_range(0, 31)), 2'($urandom)};
        core_wdata = $urandom;
      end
      if (!(dma_req && !dg)) begin
        dma_req = ($urandom_range(0, 9) < 6);
        dma_lock = ($urandom_range(0, 9) < 5);
        dma_we = 1'($urandom_range(0, 1));
        dma_wmask = 4'($urandom);
        dma_addr = {22'd0, 8'($urandom_range(0, 31)), 2'($urandom)};
        dma_wdata = $urandom;
      end
      @(negedge clk);
      cg = core_gnt; dg = dma_gnt;
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin
        errors++; $display("FAIL mem_contents word %0d got %h need %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    pre_we = 0; pre_idx = 8'h0; pre_data = 32'h0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    preload();
    test_reset();
    test_core_read();
    test_priority_wait();
    test_dma_burst();
    test_byte_write_raw();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
